mux_array_mult: RTL and testbench

- Unsigned WIDTH x WIDTH array multiplier built from mux-based multiplier cells and full adders.
- The combinational product is captured in an output register.
- Used as the registered multiply leaf in the mux-based multiplier datapath. Default WIDTH=2 yields the 2x2 -> 4-bit product.

---
 rtl/mux_mult_pkg.sv | 12 +
 rtl/mux_mult_cell.sv | 21 ++
 rtl/mux_array_mult.sv | 81 ++++++++
 tb/tb_mux_array_mult.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mux_mult_pkg.sv
// Shared constants and types for the mux-based multiplier datapath.
package mux_mult_pkg;

    localparam int DEFAULT_WIDTH = 2;

    function automatic int product_width(input int w);
        return 2 * w;
    endfunction

    typedef logic [2*DEFAULT_WIDTH-1:0] product_t;

endpackage

// File: rtl/mux_mult_cell.sv
// One array-multiplier cell: mux-formed partial product x&y folded into a
// full adder with the incoming sum and carry.
module mux_mult_cell (
    input  logic xb,
    input  logic yb,
    input  logic sin,
    input  logic cin,
    output logic sout,
    output logic cout
);

    logic pp;

    // The multiplier bit selects between the multiplicand bit and zero.
    always_comb begin
        pp   = yb ? xb : 1'b0;
        sout = pp ^ sin ^ cin;
        cout = (pp & sin) | (pp & cin) | (sin & cin);
    end

endmodule

// File: rtl/mux_array_mult.sv
// Registered unsigned WIDTH x WIDTH carry-save array multiplier built from
// mux_mult_cell, finished by a ripple row and a single output register.
module mux_array_mult
    import mux_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 x,
    input  logic [WIDTH-1:0]                 y,
    output logic [product_width(WIDTH)-1:0]  p,
    output logic                             out_valid
);

    logic [WIDTH-1:0]                low_bits;
    logic [WIDTH-1:0]                hi_s;
    logic [WIDTH-1:0]                last_c;
    logic [WIDTH-1:0]                hi_bits;
    logic                            carry;
    logic [product_width(WIDTH)-1:0] prod;

    // Row j holds the cells of weight i+j; each row consumes the previous
    // row's sums shifted down one column and its carries in the same column.
    for (genvar j = 0; j < WIDTH; j++) begin : row
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] sin;
        logic [WIDTH-1:0] cin;

        if (j == 0) begin : first
            assign sin = '0;
            assign cin = '0;
        end else begin : rest
            assign sin = {1'b0, row[j-1].s[WIDTH-1:1]};
            assign cin = row[j-1].c;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : col
            mux_mult_cell u_cell (
                .xb   (x[i]),
                .yb   (y[j]),
                .sin  (sin[i]),
                .cin  (cin[i]),
                .sout (s[i]),
                .cout (c[i])
            );
        end

        assign low_bits[j] = s[0];
    end

    assign hi_s   = {1'b0, row[WIDTH-1].s[WIDTH-1:1]};
    assign last_c = row[WIDTH-1].c;

    // Final ripple row resolves the leftover sums and carries into the upper
    // half; its carry-out is always zero since the product cannot overflow.
    always_comb begin
        carry   = 1'b0;
        hi_bits = '0;
        for (int k = 0; k < WIDTH; k++) begin
            hi_bits[k] = hi_s[k] ^ last_c[k] ^ carry;
            carry      = (hi_s[k] & last_c[k]) | (hi_s[k] & carry) | (last_c[k] & carry);
        end
        prod = {hi_bits, low_bits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                p <= prod;
            end
        end
    end

endmodule

// File: tb/tb_mux_array_mult.sv
// Directed and random checks of mux_array_mult at WIDTH=2 and WIDTH=4.
module tb_mux_array_mult;
    import mux_mult_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       v2;
    logic [1:0] x2;
    logic [1:0] y2;
    logic [3:0] p2;
    logic       o2;
    logic       v4;
    logic [3:0] x4;
    logic [3:0] y4;
    logic [7:0] p4;
    logic       o4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_array_mult #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v2),
        .x         (x2),
        .y         (y2),
        .p         (p2),
        .out_valid (o2)
    );

    mux_array_mult #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v4),
        .x         (x4),
        .y         (y4),
        .p         (p4),
        .out_valid (o4)
    );

    task automatic applyStimulus(input logic r, input logic va, input logic [1:0] a, input logic [1:0] b,
                                 input logic vb, input logic [3:0] c, input logic [3:0] d);
        reset = r;
        v2    = va;
        x2    = a;
        y2    = b;
        v4    = vb;
        x4    = c;
        y4    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] e;
    } vec4_t;

    vec4_t corners[5] = '{
        '{4'd15, 4'd15, 8'd225},
        '{4'd15, 4'd1,  8'd15},
        '{4'd8,  4'd8,  8'd64},
        '{4'd0,  4'd15, 8'd0},
        '{4'd1,  4'd9,  8'd9}
    };

    initial begin
        product_t   e2;
        logic [7:0] e4;
        logic [3:0] r1;
        logic [3:0] r2;

        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0);
        checkOutput("rst_p2", 16'(p2), 16'd0);
        checkOutput("rst_v2", 16'(o2), 16'd0);
        checkOutput("rst_p4", 16'(p4), 16'd0);
        checkOutput("rst_v4", 16'(o4), 16'd0);

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(1'b0, 1'b1, 2'(a), 2'(b), 1'b0, 4'd0, 4'd0);
                e2 = product_t'(a * b);
                checkOutput($sformatf("exh_%0dx%0d", a, b), 16'(p2), 16'(e2));
                checkOutput("exh_valid", 16'(o2), 16'd1);
            end
        end

        applyStimulus(1'b1, 1'b1, 2'd3, 2'd2, 1'b1, 4'd15, 4'd15);
        checkOutput("rstpri_p2", 16'(p2), 16'd0);
        checkOutput("rstpri_v2", 16'(o2), 16'd0);
        checkOutput("rstpri_p4", 16'(p4), 16'd0);
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd2, 1'b0, 4'd0, 4'd0);
        checkOutput("afterrst_p2", 16'(p2), 16'd6);
        checkOutput("afterrst_v2", 16'(o2), 16'd1);

        applyStimulus(1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 4'd0, 4'd0);
        checkOutput("gate_load", 16'(p2), 16'd6);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 4'd0, 4'd0);
            checkOutput("gate_hold_p", 16'(p2), 16'd6);
            checkOutput("gate_hold_v", 16'(o2), 16'd0);
        end

        applyStimulus(1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 4'd0, 4'd0);
        checkOutput("b2b_1", 16'(p2), 16'd1);
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd2, 1'b0, 4'd0, 4'd0);
        checkOutput("b2b_2", 16'(p2), 16'd6);
        applyStimulus(1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 4'd0, 4'd0);
        checkOutput("b2b_3", 16'(p2), 16'd4);
        checkOutput("b2b_v", 16'(o2), 16'd1);

        foreach (corners[k]) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, corners[k].a, corners[k].b);
            checkOutput($sformatf("w4_%0dx%0d", corners[k].a, corners[k].b), 16'(p4), 16'(corners[k].e));
            checkOutput("w4_valid", 16'(o4), 16'd1);
        end

        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd7, 4'd7);
        checkOutput("w4_hold_p", 16'(p4), 16'd9);
        checkOutput("w4_hold_v", 16'(o4), 16'd0);

        for (int n = 0; n < 1000; n++) begin
            r1 = 4'($urandom_range(0, 15));
            r2 = 4'($urandom_range(0, 15));
            e4 = r1 * r2;
            applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, r1, r2);
            checkOutput($sformatf("rnd_%0dx%0d", r1, r2), 16'(p4), 16'(e4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
